// File: rtl/m_if_stage.sv
// m_if_stage: PC owner, sequential imem fetch, DEPTH-entry {pc, ir} queue; IF_BYPASS_EN forwards a response straight to the consumer when the queue is empty.
module m_if_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_redir,
    input  logic [31:0] w_redir_pc,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_ir,
    output logic [31:0] w_pc
);
    localparam int PW = $clog2(DEPTH);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;
    logic [31:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0] count_q, count_d;
    ent_t mem_q [DEPTH];
    ent_t mem_d [DEPTH];
    ent_t head;
    logic q_valid, resp, byp, push, pop;
    always_comb begin
        q_valid = count_q != '0;
        resp = inflight_q & ~w_redir;
`ifdef IF_BYPASS_EN
        byp = resp & ~q_valid;
`else
        byp = 1'b0;
`endif
        // registered count only: a same-cycle pop frees its slot next cycle
        w_imem_req = ~w_rst & ~w_redir &
                     (({1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q}) < (PW+2)'(DEPTH));
        w_imem_addr = pc_q;
        head = mem_q[rd_ptr_q];
        w_valid = q_valid | byp;
        w_ir = q_valid ? head.ir : byp ? w_imem_data : 32'h0000_0013;
        w_pc = q_valid ? head.pc : byp ? inflight_pc_q : 32'h0;
        pop = q_valid & w_ready;
        push = resp & ~(byp & w_ready);
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{pc: inflight_pc_q, ir: w_imem_data};
        rd_ptr_d = w_redir ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = w_redir ? '0 : wr_ptr_q + PW'(push);
        count_d = w_redir ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        pc_d = w_redir ? (w_redir_pc & ~32'h3) : w_imem_req ? pc_q + 32'd4 : pc_q;
        inflight_d = w_imem_req;
        inflight_pc_d = w_imem_req ? pc_q : inflight_pc_q;
    end
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            pc_q <= pc_d;
            inflight_q <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_m_if_stage.sv
// tb_m_if_stage: directed table, corner sequences and random traffic against a queue-based fetch model.
module tb_m_if_stage;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    logic w_clk = 1'b0;
    logic w_rst, w_redir, w_imem_req, w_valid, w_ready;
    logic [31:0] w_redir_pc, w_imem_addr, w_imem_data, w_ir, w_pc;
    int compared = 0;
    int mismatched = 0;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;
    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] ir;
    } vec_t;
    ent_t mq[$];
    logic [31:0] m_pc, m_ipc;
    bit m_infl;
    logic a_req, a_valid;
    logic [31:0] a_addr, a_ir, a_pc;
    vec_t tv [7];
    logic [31:0] wrap_exp [4];

    m_if_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_redir(w_redir), .w_redir_pc(w_redir_pc),
        .w_imem_req(w_imem_req), .w_imem_addr(w_imem_addr), .w_imem_data(w_imem_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_ir(w_ir), .w_pc(w_pc)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock cycle: drive, compare against the model mid-cycle, advance model, then answer imem
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy, input bit en);
        bit byp, e_req, e_valid;
        logic [31:0] e_ir, e_pc;
        ent_t e;
        w_rst = rst;
        w_redir = redir;
        w_redir_pc = rpc;
        w_ready = rdy;
        #4;
`ifdef IF_BYPASS_EN
        byp = mq.size() == 0 && m_infl && !redir;
`else
        byp = 1'b0;
`endif
        e_req = !rst && !redir && (mq.size() + int'(m_infl) < DEPTH);
        e_valid = mq.size() > 0 || byp;
        if (mq.size() > 0) begin
            e_pc = mq[0].pc;
            e_ir = mq[0].ir;
        end else if (byp) begin
            e_pc = m_ipc;
            e_ir = imem(m_ipc);
        end else begin
            e_pc = 32'h0;
            e_ir = NOP;
        end
        a_req = w_imem_req;
        a_addr = w_imem_addr;
        a_valid = w_valid;
        a_ir = w_ir;
        a_pc = w_pc;
        if (en) begin
            chk("req", 32'(a_req), 32'(e_req));
            chk("addr", a_addr, m_pc);
            chk("valid", 32'(a_valid), 32'(e_valid));
            chk("ir", a_ir, e_ir);
            chk("pc", a_pc, e_pc);
        end
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC;
            m_infl = 1'b0;
        end else if (redir) begin
            mq.delete();
            m_pc = rpc & ~32'h3;
            m_infl = 1'b0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (m_infl && !(byp && rdy)) begin
                e.pc = m_ipc;
                e.ir = imem(m_ipc);
                mq.push_back(e);
            end
            if (e_req) begin
                m_ipc = m_pc;
                m_pc = m_pc + 32'd4;
                m_infl = 1'b1;
            end else m_infl = 1'b0;
        end
        @(posedge w_clk);
        #1;
        w_imem_data = a_req ? imem(a_addr) : 32'hBAD0_BAD0;
    endtask

    initial begin
        int n;
        w_rst = 1'b1;
        w_redir = 1'b0;
        w_redir_pc = 32'h0;
        w_ready = 1'b1;
        w_imem_data = 32'h0;
        m_pc = RESET_PC;
        m_ipc = 32'h0;
        m_infl = 1'b0;
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        tv[0] = '{1, 1, 0, 32'h0, 0, 32'h0, NOP};
        tv[1] = '{0, 1, 1, 32'h0, 0, 32'h0, NOP};
`ifdef IF_BYPASS_EN
        tv[2] = '{0, 1, 1, 32'h4,  1, 32'h0,  32'h0};
        tv[3] = '{0, 1, 1, 32'h8,  1, 32'h4,  32'h1};
        tv[4] = '{0, 1, 1, 32'hC,  1, 32'h8,  32'h2};
        tv[5] = '{0, 1, 1, 32'h10, 1, 32'hC,  32'h3};
        tv[6] = '{0, 1, 1, 32'h14, 1, 32'h10, 32'h4};
`else
        tv[2] = '{0, 1, 1, 32'h4,  0, 32'h0, NOP};
        tv[3] = '{0, 1, 0, 32'h8,  1, 32'h0, 32'h0};
        tv[4] = '{0, 1, 1, 32'h8,  1, 32'h4, 32'h1};
        tv[5] = '{0, 1, 1, 32'hC,  0, 32'h0, NOP};
        tv[6] = '{0, 1, 0, 32'h10, 1, 32'h8, 32'h2};
`endif
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(tv[i].rst, 0, 0, tv[i].rdy, 1);
            chk($sformatf("tbl%0d_req", i), 32'(a_req), 32'(tv[i].req));
            chk($sformatf("tbl%0d_addr", i), a_addr, tv[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(tv[i].valid));
            chk($sformatf("tbl%0d_pc", i), a_pc, tv[i].pc);
            chk($sformatf("tbl%0d_ir", i), a_ir, tv[i].ir);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        chk("bp_req", 32'(a_req), 32'h0);
        chk("bp_valid", 32'(a_valid), 32'h1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h200, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h103, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("rd_req", 32'(a_req), 32'h1);
        chk("rd_addr", a_addr, 32'h100);
        step(0, 0, 0, 1, 1);
`ifndef IF_BYPASS_EN
        chk("rd_gap", 32'(a_valid), 32'h0);
        step(0, 0, 0, 1, 1);
`endif
        chk("rd_valid", 32'(a_valid), 32'h1);
        chk("rd_pc", a_pc, 32'h100);
        chk("rd_ir", a_ir, 32'h40);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_ir", a_ir, NOP);
        chk("rst_addr", a_addr, RESET_PC);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
        step(0, 1, 32'hFFFF_FFF8, 1, 1);
        n = 0;
        for (int i = 0; i < 12 && n < 4; i++) begin
            step(0, 0, 0, 1, 1);
            if (a_req) begin
                chk($sformatf("wrap%0d", n), a_addr, wrap_exp[n]);
                n++;
            end
        end
        if (n < 4) begin
            compared++;
            mismatched++;
            $display("FAIL wrap_timeout: got %0d fetches, want 4", n);
        end
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 63);
            step(r == 0, r >= 1 && r <= 4, $urandom, $urandom_range(0, 9) < 7, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
